// File: rtl/interrupt_controller_prio.sv
// N-source interrupt controller: edge/level capture, mie masking,
// fixed or round-robin arbitration, one-cycle strobe, cause held to ack.
module interrupt_controller_prio #(
  parameter int          N_SRC     = 32,
  parameter logic [31:0] EDGE_MASK = 32'h0000_0000,
  parameter bit          RR_MODE   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] int_int_req_i,
  input  logic [N_SRC-1:0] int_mie_i,
  input  logic             int_rst_i,
  output logic [31:0]      int_mcause_o,
  output logic             int_int_o,
  output logic             int_busy_o
);

  localparam int IW = $clog2(N_SRC);
  localparam logic [N_SRC-1:0] EM = EDGE_MASK[N_SRC-1:0];
  localparam logic [N_SRC-1:0] ONE = {{(N_SRC-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q;
  logic [N_SRC-1:0] req_q;
  logic [N_SRC-1:0] edge_q;
  logic [N_SRC-1:0] edge_d;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] clr;
  logic [IW-1:0]    rr_q;
  logic [IW-1:0]    mcause_q;
  logic [IW-1:0]    win;
  logic [IW-1:0]    sel;
  logic [IW:0]      sum;
  logic             found;
  logic             int_q;
  logic             busy_q;
  logic             ack;

  assign ack  = (state_q == BUSY) && int_rst_i;
  assign clr  = ack ? (ONE << mcause_q) : '0;

  // a fresh rising edge beats the clear of the same bit
  assign edge_d = ((edge_q & ~clr) | (int_int_req_i & ~req_q)) & EM;

  assign pend = (edge_q & EM) | (int_int_req_i & ~EM);
  assign elig = pend & int_mie_i;

  // pick the winner: lowest index, or first index after rr pointer
  always_comb begin
    win   = '0;
    found = 1'b0;
    sum   = '0;
    sel   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (RR_MODE) begin
        sum = {1'b0, rr_q} + (IW+1)'(k + 1);
        if (sum >= (IW+1)'(N_SRC)) begin
          sum = sum - (IW+1)'(N_SRC);
        end
        sel = sum[IW-1:0];
      end else begin
        sel = IW'(k);
      end
      if (!found && elig[sel]) begin
        found = 1'b1;
        win   = sel;
      end
    end
  end

  // request history and latched edge-pending bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q  <= '0;
      edge_q <= '0;
    end else begin
      req_q  <= int_int_req_i;
      edge_q <= edge_d;
    end
  end

  // accept / hold-until-ack control with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      mcause_q <= '0;
      int_q    <= 1'b0;
      busy_q   <= 1'b0;
      rr_q     <= IW'(N_SRC - 1);
    end else begin
      unique case (state_q)
        IDLE: begin
          int_q <= 1'b0;
          if (found) begin
            state_q  <= BUSY;
            mcause_q <= win;
            int_q    <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        BUSY: begin
          int_q <= 1'b0;
          if (int_rst_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            rr_q    <= mcause_q;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign int_mcause_o = {{(32-IW){1'b0}}, mcause_q};
  assign int_int_o    = int_q;
  assign int_busy_o   = busy_q;

endmodule

// File: tb/tb_interrupt_controller_prio.sv
// Scoreboard bench: fixed-priority and round-robin instances against
// a behavioural model of the pending/arbitration/ack rules.
module tb_interrupt_controller_prio;

  localparam int N0 = 8;
  localparam int N1 = 5;
  localparam logic [31:0] EM0 = 32'h0000_0064;
  localparam logic [31:0] EM1 = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  req;
  logic [7:0]  mie;
  logic        ack0;
  logic        ack1;
  logic [31:0] mc0;
  logic [31:0] mc1;
  logic        int0;
  logic        int1;
  logic        busy0;
  logic        busy1;

  interrupt_controller_prio #(
    .N_SRC(N0), .EDGE_MASK(EM0), .RR_MODE(1'b0)
  ) u0 (
    .clk(clk), .reset(reset),
    .int_int_req_i(req), .int_mie_i(mie),
    .int_rst_i(ack0), .int_mcause_o(mc0),
    .int_int_o(int0), .int_busy_o(busy0)
  );

  interrupt_controller_prio #(
    .N_SRC(N1), .EDGE_MASK(EM1), .RR_MODE(1'b1)
  ) u1 (
    .clk(clk), .reset(reset),
    .int_int_req_i(req[N1-1:0]), .int_mie_i(mie[N1-1:0]),
    .int_rst_i(ack1), .int_mcause_o(mc1),
    .int_int_o(int1), .int_busy_o(busy1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stamp;
    logic [1:0]  strb;
    logic [1:0]  bsy;
    logic [31:0] c0;
    logic [31:0] c1;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;
  int   edge_n = 0;
  bit   mon_en = 1'b0;

  bit m_busy[2];
  int m_cause[2];
  int m_ptr[2];
  bit m_pe[2][8];
  bit m_rq[2][8];

  always @(posedge clk) edge_n++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at edge %0d: got %0h want %0h",
               nm, edge_n, act, exp);
    end
  endtask

  function automatic int nsrc(input int d);
    return (d == 0) ? N0 : N1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d]  = 1'b0;
      m_cause[d] = 0;
      m_ptr[d]   = nsrc(d) - 1;
      for (int i = 0; i < 8; i++) begin
        m_pe[d][i] = 1'b0;
        m_rq[d][i] = 1'b0;
      end
    end
  endtask

  // outcome of the coming clock edge for instance d
  task automatic model_step(input int d, output bit st);
    int          n;
    int          win;
    int          clr;
    int          idx;
    logic [31:0] em;
    bit          a;
    bit          elig[8];
    n   = nsrc(d);
    em  = (d == 0) ? EM0 : EM1;
    a   = (d == 0) ? ack0 : ack1;
    win = -1;
    clr = -1;
    st  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      elig[i] = (i < n) && mie[i] && (em[i] ? m_pe[d][i] : req[i]);
    end
    if (!m_busy[d]) begin
      for (int k = 0; k < n; k++) begin
        idx = (d == 1) ? (m_ptr[d] + 1 + k) % n : k;
        if (win < 0 && elig[idx]) win = idx;
      end
      if (win >= 0) begin
        m_busy[d]  = 1'b1;
        m_cause[d] = win;
        st         = 1'b1;
      end
    end else if (a) begin
      m_busy[d] = 1'b0;
      m_ptr[d]  = m_cause[d];
      clr       = m_cause[d];
    end
    for (int i = 0; i < n; i++) begin
      if (em[i]) begin
        m_pe[d][i] = (m_pe[d][i] && i != clr) || (req[i] && !m_rq[d][i]);
      end
      m_rq[d][i] = req[i];
    end
  endtask

  task automatic drive(input logic [7:0] r, input logic [7:0] m,
                       input logic a0, input logic a1);
    exp_t e;
    bit   s0;
    bit   s1;
    req  = r;
    mie  = m;
    ack0 = a0;
    ack1 = a1;
    model_step(0, s0);
    model_step(1, s1);
    e.stamp = edge_n + 1;
    e.strb  = {s1, s0};
    e.bsy   = {m_busy[1], m_busy[0]};
    e.c0    = m_cause[0];
    e.c1    = m_cause[1];
    q.push_back(e);
  endtask

  task automatic step(input logic [7:0] r, input logic [7:0] m,
                      input logic a0, input logic a1);
    @(posedge clk);
    #2;
    drive(r, m, a0, a1);
  endtask

  task automatic rst_zero();
    chk("rst_int0", 32'(int0), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_mcause0", mc0, 32'd0);
    chk("rst_int1", 32'(int1), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_mcause1", mc1, 32'd0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    q.delete();
    reset = 1'b0;
    req   = 8'hFF;
    ack0  = 1'b0;
    ack1  = 1'b0;
    #1;
    rst_zero();
    repeat (n) begin
      @(negedge clk);
      rst_zero();
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    drive(8'h00, 8'hFF, 1'b0, 1'b0);
    mon_en = 1'b1;
  endtask

  // scoreboard monitor: compare each presented cycle with its prediction
  always @(negedge clk) begin
    if (mon_en && q.size() > 0) begin
      if (q[0].stamp < edge_n) begin
        vecs++;
        errs++;
        $display("FAIL lost_entry stamp %0d at edge %0d",
                 q[0].stamp, edge_n);
        void'(q.pop_front());
      end else if (q[0].stamp == edge_n) begin
        exp_t e;
        e = q.pop_front();
        chk("int0", 32'(int0), 32'(e.strb[0]));
        chk("busy0", 32'(busy0), 32'(e.bsy[0]));
        chk("mcause0", mc0, e.c0);
        chk("int1", 32'(int1), 32'(e.strb[1]));
        chk("busy1", 32'(busy1), 32'(e.bsy[1]));
        chk("mcause1", mc1, e.c1);
      end
    end
  end

  initial begin
    bit did_rst;
    reset = 1'b0;
    req   = 8'hFF;
    mie   = 8'hFF;
    ack0  = 1'b0;
    ack1  = 1'b0;
    did_rst = 1'b0;
    model_reset();
    do_reset(3);

    // fixed priority on level lines 3 and 7
    repeat (4) step(8'h88, 8'hFF, 1'b0, 1'b0);
    step(8'h88, 8'hFF, 1'b1, 1'b1);
    repeat (4) step(8'h88, 8'hFF, 1'b0, 1'b0);
    step(8'h80, 8'hFF, 1'b1, 1'b1);
    repeat (4) step(8'h80, 8'hFF, 1'b0, 1'b0);
    step(8'h00, 8'hFF, 1'b1, 1'b1);
    repeat (2) step(8'h00, 8'hFF, 1'b0, 1'b0);

    // masked edge on source 5 stays latched until enabled
    step(8'h20, 8'hDF, 1'b0, 1'b0);
    repeat (4) step(8'h00, 8'hDF, 1'b0, 1'b0);
    repeat (3) step(8'h00, 8'hFF, 1'b0, 1'b0);
    step(8'h00, 8'hFF, 1'b1, 1'b1);
    repeat (4) step(8'h00, 8'hFF, 1'b0, 1'b0);

    // round-robin rotation over 0,1,2
    repeat (4) begin
      repeat (3) step(8'h07, 8'hFF, 1'b0, 1'b0);
      step(8'h07, 8'hFF, 1'b1, 1'b1);
    end
    repeat (2) step(8'h00, 8'hFF, 1'b1, 1'b1);

    // busy hold: edge on 2 while source 4 is outstanding
    repeat (3) step(8'h10, 8'hFF, 1'b0, 1'b0);
    step(8'h14, 8'hFF, 1'b0, 1'b0);
    repeat (3) step(8'h10, 8'hFF, 1'b0, 1'b0);
    step(8'h00, 8'hFF, 1'b1, 1'b1);
    repeat (4) step(8'h00, 8'hFF, 1'b0, 1'b0);
    step(8'h00, 8'hFF, 1'b1, 1'b1);

    // ack of 6 colliding with a new edge on 6, then ack in idle
    step(8'h40, 8'h40, 1'b0, 1'b0);
    repeat (3) step(8'h00, 8'h40, 1'b0, 1'b0);
    step(8'h40, 8'h40, 1'b1, 1'b0);
    repeat (3) step(8'h00, 8'h40, 1'b0, 1'b0);
    step(8'h00, 8'h40, 1'b1, 1'b0);
    repeat (2) step(8'h00, 8'h40, 1'b0, 1'b0);
    step(8'h00, 8'h00, 1'b1, 1'b1);
    repeat (3) step(8'h00, 8'h00, 1'b0, 1'b0);

    // random traffic with one asynchronous reset while busy
    for (int i = 0; i < 4000; i++) begin
      if (i >= 2000 && !did_rst && m_busy[0]) begin
        do_reset(2);
        did_rst = 1'b1;
      end else begin
        step(8'($urandom & $urandom), 8'($urandom | $urandom),
             1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 3) == 0));
      end
    end

    repeat (3) step(8'h00, 8'h00, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
